// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle shift-and-add multiplier that borrows the
// shared execute-stage ALU. It produces the low XLEN bits of op_a * op_b.
// Optional feature macro: MULSEQ_EARLY_EXIT_EN. When it is defined, zero
// multiplier bits skip the ADD step and sequencing stops as soon as the
// remaining multiplier is zero. When it is undefined, every bit runs ADD then
// SHIFT, so the latency is fixed.
module alu_mul_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic             result_zero,
    output logic             alu_req,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    state_t            state;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   mplier_shr;
    logic              last_iter;

    assign mplier_shr = mplier >> 1;

`ifdef MULSEQ_EARLY_EXIT_EN
    // Stop after the final bit, or as soon as no set multiplier bits remain.
    assign last_iter = (cnt == CNT_W'(XLEN - 1)) || (mplier_shr == '0);
`else
    // Always walk all XLEN multiplier bits.
    assign last_iter = (cnt == CNT_W'(XLEN - 1));
`endif

    // ALU drive is a Moore decode of the state and the internal registers.
    // In ADD, a clear multiplier bit adds zero. That case occurs only in the
    // fixed-latency build.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 4'b0000;
        case (state)
            ADD: begin
                alu_a    = acc;
                alu_b    = mplier[0] ? mcand : '0;
                alu_ctrl = ALU_ADD;
            end
            SHIFT: begin
                alu_a    = mcand;
                alu_b    = XLEN'(1);
                alu_ctrl = ALU_SLL;
            end
            DONE: begin
                alu_a    = acc;
                alu_b    = '0;
                alu_ctrl = ALU_OR;
            end
            default: ;
        endcase
    end

    // Sequencer FSM: updates the datapath registers and the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            alu_req     <= 1'b0;
            result      <= '0;
            result_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        mcand   <= op_a;
                        mplier  <= op_b;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        alu_req <= 1'b1;
`ifdef MULSEQ_EARLY_EXIT_EN
                        if (op_b == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (op_b[0]) begin
                            state <= ADD;
                        end else begin
                            state <= SHIFT;
                        end
`else
                        state <= ADD;
`endif
                    end
                end
                ADD: begin
                    acc   <= alu_result;
                    state <= SHIFT;
                end
                SHIFT: begin
                    mcand  <= alu_result;
                    mplier <= mplier_shr;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
`ifdef MULSEQ_EARLY_EXIT_EN
                        state <= mplier[1] ? ADD : SHIFT;
`else
                        state <= ADD;
`endif
                    end
                end
                DONE: begin
                    result      <= alu_result;
                    result_zero <= alu_zero;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    alu_req     <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
